// File: rtl/or1200_keystream_gen.sv
// Keystream pad generator: builds a seed from row/col/tb/db/cntr fields, drives an
// external block cipher through a ld/done handshake and prefetches pads into a FIFO.
// Optional CTR mode is compiled in when OR1200_KSG_CTR_MODE_EN is defined; otherwise
// the generator always runs in OFB mode and the mode input is ignored.
module or1200_keystream_gen #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNTR_W = 16,
  parameter int unsigned PAD_W  = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_wr,
  input  logic [2:0]       seed_sel,
  input  logic [31:0]      seed_data,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             pad_rd,
  output logic [PAD_W-1:0] pad_out,
  output logic             pad_valid,
  output logic             unstall,
  output logic             busy,
  output logic             cipher_ld,
  output logic [PAD_W-1:0] cipher_text_in,
  input  logic             cipher_done,
  input  logic [PAD_W-1:0] cipher_text_out
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam int unsigned CNTR_LSB = 72;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_t;

  state_t             r_state;
  logic [31:0]        r_row;
  logic [15:0]        r_col, r_tb;
  logic [7:0]         r_db;
  logic [CNTR_W-1:0]  r_cntr;
  logic               r_start_q;
  logic [PAD_W-1:0]   r_iv, r_fb, r_text_in, r_pad_out;
  logic               r_first, r_stop_pend, r_restart_pend, r_cipher_ld;
  logic [PAD_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [CW-1:0]      r_count;

  logic [PAD_W-1:0]   w_seed, w_issue_in;
  logic               w_start_edge, w_latch, w_issue, w_push, w_pop;
  logic [CW-1:0]      w_count_after;
  logic [AW-1:0]      w_rptr_nxt;

  // Seed field registers; sel 5-7 are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_tb   <= '0;
      r_db   <= '0;
      r_cntr <= '0;
    end else if (seed_wr) begin
      case (seed_sel)
        3'd0:    r_row  <= seed_data;
        3'd1:    r_col  <= seed_data[15:0];
        3'd2:    r_tb   <= seed_data[15:0];
        3'd3:    r_db   <= seed_data[7:0];
        3'd4:    r_cntr <= CNTR_W'(seed_data);
        default: ;
      endcase
    end
  end

  // Seed block assembled as {zeros, cntr, db, tb, col, row}.
  always_comb begin
    w_seed                         = '0;
    w_seed[31:0]                   = r_row;
    w_seed[47:32]                  = r_col;
    w_seed[63:48]                  = r_tb;
    w_seed[71:64]                  = r_db;
    w_seed[CNTR_LSB +: CNTR_W]     = r_cntr;
  end

  // Previous start level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) r_start_q <= 1'b0;
    else     r_start_q <= start;
  end

  assign w_start_edge = start & ~r_start_q;
  // A restart in WAIT is deferred until the in-flight result returns and is dropped.
  assign w_latch = (w_start_edge && (r_state != StWait)) ||
                   ((r_state == StWait) && cipher_done && (r_restart_pend || w_start_edge));
  assign w_issue = (r_state == StIssue) && !w_start_edge;
  assign w_push  = (r_state == StWait) && cipher_done && !r_restart_pend && !w_start_edge;
  assign w_pop   = pad_rd && (r_count != '0);
  assign w_count_after = r_count + CW'(1) - (w_pop ? CW'(1) : CW'(0));
  assign w_rptr_nxt    = r_rptr + AW'(1);

  // IV latch, first-issue flag and OFB feedback.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iv    <= '0;
      r_fb    <= '0;
      r_first <= 1'b0;
    end else begin
      if (w_latch)      begin r_iv <= w_seed; r_first <= 1'b1; end
      else if (w_issue) r_first <= 1'b0;
      if (w_push)       r_fb <= cipher_text_out;
    end
  end

`ifdef OR1200_KSG_CTR_MODE_EN
  logic [CNTR_W-1:0] r_offset;
  logic              r_mode;
  logic [PAD_W-1:0]  w_ctr_blk;

  // Counter offset and mode, captured per keystream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_offset <= '0;
      r_mode   <= 1'b0;
    end else if (w_latch) begin
      r_offset <= '0;
      r_mode   <= mode;
    end else if (w_issue) begin
      r_offset <= r_offset + CNTR_W'(1);
    end
  end

  // Cipher input: CTR replaces the cntr field, OFB chains the previous pad.
  always_comb begin
    w_ctr_blk                      = r_iv;
    w_ctr_blk[CNTR_LSB +: CNTR_W]  = r_iv[CNTR_LSB +: CNTR_W] + r_offset;
    w_issue_in                     = r_mode ? w_ctr_blk : (r_first ? r_iv : r_fb);
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;

  // Cipher input: IV first, then the previous pad.
  always_comb w_issue_in = r_first ? r_iv : r_fb;
`endif

  // Control FSM with registered cipher_ld / cipher_text_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_stop_pend    <= 1'b0;
      r_restart_pend <= 1'b0;
      r_cipher_ld    <= 1'b0;
      r_text_in      <= '0;
    end else begin
      r_cipher_ld <= 1'b0;
      if (w_latch) begin
        r_stop_pend    <= 1'b0;
        r_restart_pend <= 1'b0;
      end
      unique case (r_state)
        StIdle: if (w_start_edge) r_state <= StIssue;
        StIssue: begin
          if (!w_start_edge) begin
            r_cipher_ld <= 1'b1;
            r_text_in   <= w_issue_in;
            r_state     <= StWait;
            if (stop) r_stop_pend <= 1'b1;
          end
        end
        StWait: begin
          if (cipher_done && (r_restart_pend || w_start_edge)) begin
            r_state <= StIssue;
          end else if (w_start_edge) begin
            r_restart_pend <= 1'b1;
            r_stop_pend    <= 1'b0;
          end else if (cipher_done) begin
            r_stop_pend <= 1'b0;
            if (r_stop_pend || stop)             r_state <= StIdle;
            else if (w_count_after < CW'(DEPTH)) r_state <= StIssue;
            else                                 r_state <= StHold;
          end else if (stop) begin
            r_stop_pend <= 1'b1;
          end
        end
        StHold: begin
          if (w_start_edge)               r_state <= StIssue;
          else if (stop)                  r_state <= StIdle;
          else if (r_count < CW'(DEPTH))  r_state <= StIssue;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Pad storage; flushed entries are simply abandoned.
  always_ff @(posedge clk) begin
    if (w_push && !w_start_edge) r_mem[r_wptr] <= cipher_text_out;
  end

  // FIFO pointers, occupancy and registered head; flush beats push and pop.
  always_ff @(posedge clk) begin
    if (rst || w_start_edge) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_pad_out <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= w_rptr_nxt;
      r_count <= r_count + (w_push ? CW'(1) : CW'(0)) - (w_pop ? CW'(1) : CW'(0));
      if (w_pop) begin
        if (r_count > CW'(1)) r_pad_out <= r_mem[w_rptr_nxt];
        else if (w_push)      r_pad_out <= cipher_text_out;
        else                  r_pad_out <= '0;
      end else if (w_push && (r_count == '0)) begin
        r_pad_out <= cipher_text_out;
      end
    end
  end

  assign pad_out        = r_pad_out;
  assign pad_valid      = (r_count != '0);
  assign unstall        = !(pad_rd && !pad_valid);
  assign busy           = (r_state != StIdle);
  assign cipher_ld      = r_cipher_ld;
  assign cipher_text_in = r_text_in;

endmodule

// File: tb/tb_or1200_keystream_gen.sv
// Bench for or1200_keystream_gen: XOR cipher model with 10-cycle latency, vector table
// for seed layout / mode sequences, plus hand-written unstall, restart and reset cases.
module tb_or1200_keystream_gen;

  localparam logic [127:0] KEY = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
`ifdef OR1200_KSG_CTR_MODE_EN
  localparam bit CTR_EN = 1'b1;
`else
  localparam bit CTR_EN = 1'b0;
`endif

  logic         clk, rst, seed_wr, start, stop, mode, pad_rd;
  logic [2:0]   seed_sel;
  logic [31:0]  seed_data;
  logic [127:0] pad_out, cipher_text_in, cipher_text_out;
  logic         pad_valid, unstall, busy, cipher_ld, cipher_done;

  int n_pass  = 0;
  int n_total = 0;
  logic [127:0] ld_log[$];

  typedef struct {
    logic [31:0]  row;
    logic [15:0]  col;
    logic [15:0]  tb;
    logic [7:0]   db;
    logic [15:0]  cntr;
    logic         mode;
    logic [127:0] in0;
    logic [127:0] in1_ctr;
  } vec_t;

  vec_t vecs[4];

  or1200_keystream_gen #(.DEPTH(4), .CNTR_W(16), .PAD_W(128)) dut (
    .clk             (clk),
    .rst             (rst),
    .seed_wr         (seed_wr),
    .seed_sel        (seed_sel),
    .seed_data       (seed_data),
    .start           (start),
    .stop            (stop),
    .mode            (mode),
    .pad_rd          (pad_rd),
    .pad_out         (pad_out),
    .pad_valid       (pad_valid),
    .unstall         (unstall),
    .busy            (busy),
    .cipher_ld       (cipher_ld),
    .cipher_text_in  (cipher_text_in),
    .cipher_done     (cipher_done),
    .cipher_text_out (cipher_text_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cipher model: result = input ^ KEY, done sampled 10 edges after the ld edge.
  initial begin
    logic [127:0] blk;
    cipher_done     = 1'b0;
    cipher_text_out = '0;
    forever begin
      @(negedge clk);
      if (cipher_ld) begin
        blk = cipher_text_in;
        repeat (9) @(posedge clk);
        #1 cipher_done = 1'b1;
        cipher_text_out = blk ^ KEY;
        @(posedge clk);
        #1 cipher_done = 1'b0;
      end
    end
  end

  // Log every cipher issue.
  initial forever begin
    @(negedge clk);
    if (cipher_ld) ld_log.push_back(cipher_text_in);
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    start = 1'b0; stop = 1'b0; pad_rd = 1'b0; seed_wr = 1'b0; mode = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] data);
    @(posedge clk);
    #1 seed_wr = 1'b1; seed_sel = sel; seed_data = data;
    @(posedge clk);
    #1 seed_wr = 1'b0;
  endtask

  task automatic load_seed(input vec_t v);
    wr(3'd0, v.row);
    wr(3'd1, 32'(v.col));
    wr(3'd2, 32'(v.tb));
    wr(3'd3, 32'(v.db));
    wr(3'd4, 32'(v.cntr));
    wr(3'd5, 32'hffff_ffff);
    mode = v.mode;
  endtask

  // Expected n-th cipher input for a vector.
  function automatic logic [127:0] exp_in(input vec_t v, input int n);
    logic [127:0] x;
    x = v.in0;
    if (v.mode && CTR_EN) x[87:72] = v.in0[87:72] + 16'(n);
    else for (int i = 0; i < n; i++) x = x ^ KEY;
    return x;
  endfunction

  initial begin
    int   base;
    logic got, pv_seen, found, any_pv, any_busy, any_ld;
    logic [127:0] exp;

    vecs[0] = '{32'h11223344, 16'haaaa, 16'h5555, 8'h7e, 16'h0001, 1'b1,
                128'h00000000_0000017e_5555aaaa_11223344,
                128'h00000000_0000027e_5555aaaa_11223344};
    vecs[1] = '{32'hdeadbeef, 16'h1234, 16'h5678, 8'h9a, 16'hffff, 1'b1,
                128'h00000000_00ffff9a_56781234_deadbeef,
                128'h00000000_0000009a_56781234_deadbeef};
    vecs[2] = '{32'h0, 16'h0, 16'h0, 8'h0, 16'h0, 1'b0, 128'h0, 128'h0};
    vecs[3] = '{32'hcafef00d, 16'h0102, 16'h0304, 8'h05, 16'h0607, 1'b0,
                128'h00000000_00060705_03040102_cafef00d, 128'h0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; pad_rd = 1'b0;
    seed_wr = 1'b0; seed_sel = '0; seed_data = '0;
    do_reset();
    check("rst_pad_out", pad_out, '0);
    check("rst_pad_valid", 128'(pad_valid), 128'(0));
    check("rst_unstall", 128'(unstall), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_cipher_ld", 128'(cipher_ld), 128'(0));
    check("rst_text_in", cipher_text_in, '0);

    // Table: fill, hold, single refill, drain, stop.
    for (int vi = 0; vi < 4; vi++) begin
      do_reset();
      load_seed(vecs[vi]);
      base = ld_log.size();
      @(posedge clk);
      #1 start = 1'b1;
      repeat (80) @(posedge clk);
      @(negedge clk);
      check("fill_ld_count", 128'(ld_log.size() - base), 128'(4));
      for (int n = 0; n < 4; n++) check("fill_ld_in", ld_log[base + n], exp_in(vecs[vi], n));
      if (vecs[vi].mode && CTR_EN) check("ctr_second_in", ld_log[base + 1], vecs[vi].in1_ctr);
      check("fill_pad_valid", 128'(pad_valid), 128'(1));
      check("fill_busy", 128'(busy), 128'(1));
      check("fill_head", pad_out, exp_in(vecs[vi], 0) ^ KEY);
      @(posedge clk);
      #1 pad_rd = 1'b1;
      @(posedge clk);
      #1 pad_rd = 1'b0;
      repeat (25) @(posedge clk);
      @(negedge clk);
      check("refill_ld_count", 128'(ld_log.size() - base), 128'(5));
      check("refill_ld_in", ld_log[base + 4], exp_in(vecs[vi], 4));
      @(posedge clk);
      #1 pad_rd = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        check("drain_head", pad_out, exp_in(vecs[vi], k) ^ KEY);
        @(posedge clk);
      end
      #1 pad_rd = 1'b0;
      @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      check("stop_busy", 128'(busy), 128'(0));
    end

    // unstall while reading an empty FIFO.
    do_reset();
    load_seed(vecs[3]);
    @(posedge clk);
    #1 start = 1'b1; pad_rd = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pad_valid) begin got = 1'b1; break; end
      check("unstall_low", 128'(unstall), 128'(0));
    end
    check("unstall_pv_rise", 128'(got), 128'(1));
    check("unstall_high", 128'(unstall), 128'(1));
    check("unstall_head", pad_out, vecs[3].in0 ^ KEY);
    @(negedge clk);
    check("unstall_popped", 128'(pad_valid), 128'(0));
    @(posedge clk);
    #1 pad_rd = 1'b0;

    // Restart in the middle of the cipher latency.
    do_reset();
    load_seed(vecs[3]);
    @(posedge clk);
    #1 start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cipher_ld) begin found = 1'b1; break; end
    end
    check("restart_first_ld", 128'(found), 128'(1));
    start = 1'b0;
    wr(3'd0, 32'h99999999);
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b1;
    pv_seen = 1'b0; found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pad_valid) pv_seen = 1'b1;
      if (cipher_ld) begin found = 1'b1; break; end
    end
    exp = vecs[3].in0;
    exp[31:0] = 32'h99999999;
    check("restart_new_ld", 128'(found), 128'(1));
    check("restart_no_push", 128'(pv_seen), 128'(0));
    check("restart_new_seed", cipher_text_in, exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pad_valid) break;
    end
    check("restart_pad_valid", 128'(pad_valid), 128'(1));
    check("restart_pad", pad_out, exp ^ KEY);

    // Reset while a result is in flight.
    do_reset();
    load_seed(vecs[0]);
    @(posedge clk);
    #1 start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cipher_ld) begin found = 1'b1; break; end
    end
    check("rstwait_ld", 128'(found), 128'(1));
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    any_pv = 1'b0; any_busy = 1'b0; any_ld = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      any_pv   |= pad_valid;
      any_busy |= busy;
      any_ld   |= cipher_ld;
    end
    check("rstwait_pad_valid", 128'(any_pv), 128'(0));
    check("rstwait_busy", 128'(any_busy), 128'(0));
    check("rstwait_ld_after", 128'(any_ld), 128'(0));
    check("rstwait_pad_out", pad_out, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
